// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX frame path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] MUX_START = 2'd0;
  localparam logic [1:0] MUX_DATA  = 2'd1;
  localparam logic [1:0] MUX_PAR   = 2'd2;
  localparam logic [1:0] MUX_STOP  = 2'd3;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of one data word; even or odd selected by par_typ.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (par_typ == PAR_EVEN) ? (^data) : ~(^data);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start bit, LSB-first data via serializer, optional parity, stop bit(s).
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_done,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_data_in,
  output logic [1:0]            mux_sel,
  output logic                  par_bit,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  ser_err
);

  localparam int              WD_W      = $clog2(DATA_WIDTH + 2);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(DATA_WIDTH);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e       state, state_nxt;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            stop_cnt, stop_nxt;
  logic            err_q, err_nxt;
  logic            par_en_q;
  logic            par_calc;
  logic            accept;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (p_data),
    .par_typ(par_typ),
    .par_bit(par_calc)
  );

  assign ser_data_in = p_data;
  assign accept      = (state == IDLE) && data_valid;
  assign ser_err     = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wd_cnt   <= '0;
      stop_cnt <= 1'b0;
      err_q    <= 1'b0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wd_cnt   <= wd_nxt;
      stop_cnt <= stop_nxt;
      err_q    <= err_nxt;
      if (accept) begin
        par_en_q <= par_en;
        par_bit  <= par_calc;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    wd_nxt     = '0;
    stop_nxt   = 1'b0;
    err_nxt    = 1'b0;
    ser_load   = 1'b0;
    ser_en     = 1'b0;
    mux_sel    = MUX_STOP;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy     = 1'b0;
        ser_load = data_valid;
        if (data_valid) state_nxt = START;
      end
      START: begin
        mux_sel   = MUX_START;
        state_nxt = DATA;
      end
      DATA: begin
        mux_sel = MUX_DATA;
        ser_en  = 1'b1;
        // Watchdog: the serializer gets DATA_WIDTH+1 cycles to report its last bit.
        if (ser_done) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end else if (wd_cnt == WD_LIMIT) begin
          state_nxt = STOP;
          err_nxt   = 1'b1;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      PARITY: begin
        mux_sel   = MUX_PAR;
        state_nxt = STOP;
      end
      STOP: begin
        if (stop_cnt == STOP_LAST) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          stop_nxt = stop_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are forced quiet for the whole reset cycle, not just after the edge.
    if (rst) begin
      ser_load   = 1'b0;
      ser_en     = 1'b0;
      busy       = 1'b0;
      mux_sel    = MUX_STOP;
      frame_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: two instances (1 and 2 stop bits) against a frame-level reference.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, dv1, dv2, par_en, par_typ, kill;
  logic [DW-1:0] p_data;

  logic          ser_done1, ser_load1, ser_en1, par_bit1, busy1, frame_done1, ser_err1;
  logic [DW-1:0] ser_data_in1;
  logic [1:0]    mux_sel1;
  logic          ser_done2, ser_load2, ser_en2, par_bit2, busy2, frame_done2, ser_err2;
  logic [DW-1:0] ser_data_in2;
  logic [1:0]    mux_sel2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .data_valid(dv1), .p_data(p_data), .par_en(par_en),
    .par_typ(par_typ), .ser_done(ser_done1), .ser_load(ser_load1), .ser_en(ser_en1),
    .ser_data_in(ser_data_in1), .mux_sel(mux_sel1), .par_bit(par_bit1), .busy(busy1),
    .frame_done(frame_done1), .ser_err(ser_err1)
  );

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .data_valid(dv2), .p_data(p_data), .par_en(par_en),
    .par_typ(par_typ), .ser_done(ser_done2), .ser_load(ser_load2), .ser_en(ser_en2),
    .ser_data_in(ser_data_in2), .mux_sel(mux_sel2), .par_bit(par_bit2), .busy(busy2),
    .frame_done(frame_done2), .ser_err(ser_err2)
  );

  // Serializer + line mux models, so the actual TX line can be compared bit by bit.
  logic [DW-1:0] sh1, sh2;
  int            cnt1, cnt2;
  logic          line1, line2;

  always @(posedge clk) begin
    if (ser_load1) begin sh1 <= ser_data_in1; cnt1 <= 0; end
    else if (ser_en1) begin sh1 <= sh1 >> 1; cnt1 <= cnt1 + 1; end
    if (ser_load2) begin sh2 <= ser_data_in2; cnt2 <= 0; end
    else if (ser_en2) begin sh2 <= sh2 >> 1; cnt2 <= cnt2 + 1; end
  end

  assign ser_done1 = !kill && ser_en1 && (cnt1 == DW - 1);
  assign ser_done2 = !kill && ser_en2 && (cnt2 == DW - 1);
  assign line1 = (mux_sel1 == 2'd0) ? 1'b0 : (mux_sel1 == 2'd1) ? sh1[0] :
                 (mux_sel1 == 2'd2) ? par_bit1 : 1'b1;
  assign line2 = (mux_sel2 == 2'd0) ? 1'b0 : (mux_sel2 == 2'd1) ? sh2[0] :
                 (mux_sel2 == 2'd2) ? par_bit2 : 1'b1;

  typedef struct {
    logic [1:0] mux;
    logic [4:0] flags;  // busy, ser_en, frame_done, ser_err, ser_load
    logic       line;
    logic       line_chk;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting in an IDLE cycle and checks every cycle of it against
  // the frame shape derived from the word, parity settings and stop-bit count.
  task automatic run_frame(input bit sel, input logic [DW-1:0] d, input bit pe,
                           input bit pt, input bit hold, input bit kl, input string tag);
    exp_t q[$];
    exp_t e;
    int   sb = sel ? 2 : 1;
    int   nd = kl ? DW + 1 : DW;
    logic pb = (^d) ^ pt;
    e = '{mux: 2'd0, flags: 5'b10000, line: 1'b0, line_chk: 1'b1};
    q.push_back(e);
    for (int i = 0; i < nd; i++) begin
      e = '{mux: 2'd1, flags: 5'b11000, line: (i < DW) ? d[i] : 1'b0, line_chk: !kl};
      q.push_back(e);
    end
    if (pe && !kl) begin
      e = '{mux: 2'd2, flags: 5'b10000, line: pb, line_chk: 1'b1};
      q.push_back(e);
    end
    for (int s = 0; s < sb; s++) begin
      e = '{mux: 2'd3, flags: {1'b1, 1'b0, s == sb - 1, kl && s == 0, 1'b0},
            line: 1'b1, line_chk: 1'b1};
      q.push_back(e);
    end

    if (sel) dv2 = 1'b1; else dv1 = 1'b1;
    p_data = d; par_en = pe; par_typ = pt; kill = kl;
    @(negedge clk);
    chk({tag, ".acc_load"}, sel ? ser_load2 : ser_load1, 1);
    chk({tag, ".acc_busy"}, sel ? busy2 : busy1, 0);
    chk({tag, ".acc_mux"}, sel ? mux_sel2 : mux_sel1, 3);
    chk({tag, ".acc_sdata"}, sel ? ser_data_in2 : ser_data_in1, d);

    for (int c = 0; c < q.size(); c++) begin
      @(posedge clk); #1;
      if (!hold) begin dv1 = 1'b0; dv2 = 1'b0; end
      p_data = DW'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      @(negedge clk);
      chk($sformatf("%s.c%0d.mux", tag, c), sel ? mux_sel2 : mux_sel1, q[c].mux);
      chk($sformatf("%s.c%0d.flags", tag, c),
          sel ? {busy2, ser_en2, frame_done2, ser_err2, ser_load2}
              : {busy1, ser_en1, frame_done1, ser_err1, ser_load1}, q[c].flags);
      if (q[c].line_chk)
        chk($sformatf("%s.c%0d.line", tag, c), sel ? line2 : line1, q[c].line);
      if (c == 0) chk({tag, ".par_bit"}, sel ? par_bit2 : par_bit1, pb);
    end
    @(posedge clk); #1;
    if (!hold) begin dv1 = 1'b0; dv2 = 1'b0; end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    dv1 = 1'b0; dv2 = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".idle_busy"}, {busy1, busy2}, 2'b00);
      chk({tag, ".idle_mux"}, {mux_sel1, mux_sel2}, 4'hF);
      chk({tag, ".idle_en"}, {ser_en1, ser_en2, ser_load1, ser_load2}, 4'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; dv1 = 1'b1; dv2 = 1'b1; par_en = 1'b0; par_typ = 1'b0; kill = 1'b0;
    p_data = 8'hFF;

    // Reset: outputs quiet during the reset cycle even with data_valid high
    @(negedge clk);
    chk("rst.load", {ser_load1, ser_load2}, 2'b00);
    chk("rst.busy", {busy1, busy2}, 2'b00);
    chk("rst.mux", {mux_sel1, mux_sel2}, 4'hF);
    chk("rst.misc", {ser_en1, frame_done1, ser_err1, ser_en2, frame_done2, ser_err2}, 6'h0);
    @(posedge clk); #1;
    rst = 1'b0; dv1 = 1'b0; dv2 = 1'b0;
    @(negedge clk);
    chk("rst.par_bit", {par_bit1, par_bit2}, 2'b00);
    chk("rst.idle_busy", {busy1, busy2}, 2'b00);
    @(posedge clk); #1;

    // Basic frames, no parity and both parity types
    run_frame(0, 8'hA5, 0, 0, 0, 0, "t1");
    idle_cycles(2, "t1");
    run_frame(0, 8'hA5, 1, 0, 0, 0, "t2_even");
    run_frame(0, 8'h01, 1, 1, 0, 0, "t2_odd");
    idle_cycles(1, "t2");

    // data_valid held high: only the word present in each IDLE cycle is accepted
    run_frame(0, DW'($urandom), 0, 1'($urandom), 1, 0, "t3_a");
    run_frame(0, DW'($urandom), 0, 1'($urandom), 1, 0, "t3_b");
    run_frame(0, DW'($urandom), 1, 1'($urandom), 1, 0, "t3_c");
    run_frame(0, DW'($urandom), 1, 1'($urandom), 0, 0, "t3_d");
    idle_cycles(1, "t3");

    // Two stop bits
    run_frame(1, 8'h3C, 0, 0, 0, 0, "t4_nopar");
    run_frame(1, 8'hC3, 1, 1, 0, 0, "t4_par");
    idle_cycles(1, "t4");

    // Reset in the 4th DATA cycle
    dv1 = 1'b1; p_data = 8'h96; par_en = 1'b0; par_typ = 1'b0; kill = 1'b0;
    @(posedge clk); #1; dv1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t5.data3_en", ser_en1, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("t5.rst_busy", busy1, 0);
    chk("t5.rst_en", ser_en1, 0);
    chk("t5.rst_mux", mux_sel1, 3);
    @(posedge clk); #1; rst = 1'b0;
    idle_cycles(1, "t5");
    run_frame(0, 8'h5A, 1, 1, 0, 0, "t5_after");

    // Serializer never reports done: watchdog closes the frame
    run_frame(0, 8'hF0, 1, 0, 0, 1, "t6_wd1");
    run_frame(1, 8'h0F, 0, 1, 0, 1, "t6_wd2");
    idle_cycles(1, "t6");

    // Randomized frames with random gaps (gap 0 = back-to-back)
    for (int n = 0; n < 30; n++) begin
      run_frame(1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 0,
                ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", n));
      idle_cycles($urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
